// File: rtl/music_box_sequencer.sv
// Song sequencer: walks a {note, dur} ROM on 1/32 s ticks, gates the note
// during rests and articulation gaps, and handles start/stop/loop/end-of-song.
module music_box_sequencer #(
  parameter int unsigned ADDR_W    = 7,
  parameter int unsigned SONG_LEN  = 128,
  parameter int unsigned NOTE_W    = 5,
  parameter int unsigned DUR_W     = 6,
  parameter int unsigned GAP_TICKS = 1,
  parameter int unsigned LOOP      = 0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     tick,
  output logic [ADDR_W-1:0]        rom_addr,
  input  logic [NOTE_W+DUR_W-1:0]  rom_data,
  output logic [NOTE_W-1:0]        note,
  output logic                     note_valid,
  output logic                     tick_enable,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned       GAP_W     = (GAP_TICKS > 1) ? $clog2(GAP_TICKS + 1) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SONG_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_PLAY,
    S_GAP,
    S_DONE
  } state_t;

  state_t            state, state_next;
  logic [DUR_W-1:0]  remaining;
  logic [GAP_W-1:0]  gap_cnt;
  logic [NOTE_W-1:0] rom_note;
  logic [DUR_W-1:0]  rom_dur;
  logic              aborting;
  logic              note_end;
  logic              advance;
  logic              at_last;

  assign rom_note = rom_data[NOTE_W+DUR_W-1:DUR_W];
  assign rom_dur  = rom_data[DUR_W-1:0];

  // advance = end of a note (legato) or end of its gap; both step the address
  always_comb begin
    aborting = stop && (state != S_IDLE);
    note_end = (state == S_PLAY) && tick && (remaining == DUR_W'(1));
    advance  = (note_end && (GAP_TICKS == 0)) ||
               ((state == S_GAP) && tick && (gap_cnt == GAP_W'(1)));
    at_last  = (rom_addr == LAST_ADDR);
  end

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_FETCH;
      S_FETCH: state_next = S_LOAD;
      S_LOAD:  state_next = (rom_dur == '0) ? S_DONE : S_PLAY;
      S_PLAY:  if (note_end && (GAP_TICKS != 0)) state_next = S_GAP;
      S_GAP:   state_next = S_GAP;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (advance) state_next = (at_last && (LOOP == 0)) ? S_DONE : S_FETCH;
    if (aborting) state_next = S_IDLE;
  end

  // Datapath registers; a stop freezes them so rom_addr and note are held
  always_ff @(posedge clock) begin
    if (reset) begin
      rom_addr  <= '0;
      note      <= '0;
      remaining <= '0;
      gap_cnt   <= '0;
    end else if (!aborting) begin
      case (state)
        S_IDLE: if (start) rom_addr <= '0;
        S_LOAD: if (rom_dur != '0) begin
          note      <= rom_note;
          remaining <= rom_dur;
        end
        S_PLAY: if (tick) begin
          if (remaining > DUR_W'(1))  remaining <= remaining - 1'b1;
          else if (GAP_TICKS != 0)    gap_cnt   <= GAP_W'(GAP_TICKS);
        end
        S_GAP:  if (tick) gap_cnt <= gap_cnt - 1'b1;
        default: ;
      endcase
      if (advance) begin
        if (!at_last)       rom_addr <= rom_addr + 1'b1;
        else if (LOOP != 0) rom_addr <= '0;
      end
    end
  end

  // note_valid is derived from state: only PLAY with a non-rest note sounds
  always_comb begin
    note_valid  = (state == S_PLAY) && (note != '0);
    busy        = (state != S_IDLE) && (state != S_DONE);
    tick_enable = busy;
    done        = (state == S_DONE);
  end

endmodule

// File: tb/tb_music_box_sequencer.sv
// Scoreboard bench for music_box_sequencer: four parameterisations share one
// stimulus bus; per-tick expectations are queued and checked at each tick.
module tb_music_box_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       stop  = 1'b0;
  logic       tick  = 1'b0;
  logic [6:0]  raddr  [4];
  logic [10:0] rdata  [4];
  logic [4:0]  note_w [4];
  logic        nv_w   [4];
  logic        te_w   [4];
  logic        busy_w [4];
  logic        done_w [4];
  logic [10:0] mem [128];
  int          cyc = 0;
  int          sel = 0;
  int          checks = 0;
  int          failures = 0;
  logic [14:0] obs;

  typedef struct {
    string       tag;
    logic [14:0] exp;
  } sb_t;
  sb_t sb_q[$];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  always @(posedge clock) for (int i = 0; i < 4; i++) rdata[i] <= mem[raddr[i]];

  music_box_sequencer #(.ADDR_W(7), .SONG_LEN(128), .NOTE_W(5), .DUR_W(6), .GAP_TICKS(0), .LOOP(0)) u_dut_a (
    .clock(clock), .reset(reset), .start(start), .stop(stop), .tick(tick),
    .rom_addr(raddr[0]), .rom_data(rdata[0]), .note(note_w[0]), .note_valid(nv_w[0]),
    .tick_enable(te_w[0]), .busy(busy_w[0]), .done(done_w[0]));
  music_box_sequencer #(.ADDR_W(7), .SONG_LEN(128), .NOTE_W(5), .DUR_W(6), .GAP_TICKS(1), .LOOP(0)) u_dut_b (
    .clock(clock), .reset(reset), .start(start), .stop(stop), .tick(tick),
    .rom_addr(raddr[1]), .rom_data(rdata[1]), .note(note_w[1]), .note_valid(nv_w[1]),
    .tick_enable(te_w[1]), .busy(busy_w[1]), .done(done_w[1]));
  music_box_sequencer #(.ADDR_W(7), .SONG_LEN(4), .NOTE_W(5), .DUR_W(6), .GAP_TICKS(0), .LOOP(1)) u_dut_c (
    .clock(clock), .reset(reset), .start(start), .stop(stop), .tick(tick),
    .rom_addr(raddr[2]), .rom_data(rdata[2]), .note(note_w[2]), .note_valid(nv_w[2]),
    .tick_enable(te_w[2]), .busy(busy_w[2]), .done(done_w[2]));
  music_box_sequencer #(.ADDR_W(7), .SONG_LEN(4), .NOTE_W(5), .DUR_W(6), .GAP_TICKS(0), .LOOP(0)) u_dut_d (
    .clock(clock), .reset(reset), .start(start), .stop(stop), .tick(tick),
    .rom_addr(raddr[3]), .rom_data(rdata[3]), .note(note_w[3]), .note_valid(nv_w[3]),
    .tick_enable(te_w[3]), .busy(busy_w[3]), .done(done_w[3]));

  assign obs = {raddr[sel], te_w[sel], busy_w[sel], nv_w[sel], note_w[sel]};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [14:0] exp_obs(input int addr, input logic act, input logic nv, input int nt);
    logic [6:0] a;
    logic [4:0] n;
    a = 7'(addr);
    n = 5'(nt);
    return {a, act, act, nv, n};
  endfunction

  // State seen during a tick cycle, before the tick is consumed
  always @(negedge clock) begin : monitor
    sb_t e;
    if (tick && sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check_val(e.tag, 32'(obs), 32'(e.exp));
    end
  end

  task automatic do_reset();
    @(posedge clock);
    #1 reset = 1'b1;
    sb_q.delete();
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    for (int i = 0; i < 128; i++) mem[i] = '0;
  endtask

  task automatic do_start(output int t);
    @(posedge clock);
    #1 start = 1'b1;
    t = cyc;
    @(posedge clock);
    #1 start = 1'b0;
  endtask

  task automatic do_tick(input string tag, input logic [14:0] exp, output int t);
    repeat (19) @(posedge clock);
    #1 tick = 1'b1;
    t = cyc;
    sb_q.push_back('{tag: tag, exp: exp});
    @(posedge clock);
    #1 tick = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int at, output int nv_hi);
    at = -1;
    nv_hi = 0;
    for (int i = 0; i < budget && at < 0; i++) begin
      @(negedge clock);
      if (nv_w[sel]) nv_hi++;
      if (done_w[sel]) at = cyc;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int t, at, nvh, dcnt;
    for (int i = 0; i < 128; i++) mem[i] = '0;
    repeat (3) @(posedge clock);
    #1;
    for (int i = 0; i < 4; i++)
      check_val($sformatf("reset_dut%0d", i),
                32'({raddr[i], note_w[i], nv_w[i], te_w[i], busy_w[i], done_w[i]}), 32'(0));
    reset = 1'b0;

    // song with a rest, legato
    do_reset(); sel = 0;
    mem[0] = {5'd5, 6'd3}; mem[1] = {5'd0, 6'd2}; mem[2] = {5'd9, 6'd1}; mem[3] = {5'd7, 6'd0};
    do_start(t);
    for (int k = 0; k < 3; k++) do_tick("t1_note5", exp_obs(0, 1, 1, 5), t);
    for (int k = 0; k < 2; k++) do_tick("t1_rest", exp_obs(1, 1, 0, 0), t);
    do_tick("t1_note9", exp_obs(2, 1, 1, 9), t);
    wait_done(50, at, nvh);
    check_val("t1_done_lat", at - t, 3);
    check_val("t1_addr_at_done", 32'(raddr[0]), 32'd3);
    @(negedge clock);
    check_val("t1_done_width_busy", 32'({done_w[0], busy_w[0]}), 32'd0);

    // articulation gap of one tick
    do_reset(); sel = 1;
    mem[0] = {5'd5, 6'd3};
    do_start(t);
    for (int k = 0; k < 3; k++) do_tick("t2_note5", exp_obs(0, 1, 1, 5), t);
    do_tick("t2_gap", exp_obs(0, 1, 0, 5), t);
    wait_done(50, at, nvh);
    check_val("t2_done_lat", at - t, 3);
    check_val("t2_nv_after_gap", nvh, 0);

    // stop in the middle of a note, then restart
    do_reset(); sel = 0;
    mem[0] = {5'd3, 6'd1}; mem[1] = {5'd7, 6'd3};
    do_start(t);
    do_tick("t3_note3", exp_obs(0, 1, 1, 3), t);
    do_tick("t3_note7a", exp_obs(1, 1, 1, 7), t);
    do_tick("t3_note7b", exp_obs(1, 1, 1, 7), t);
    stop = 1'b1;
    @(posedge clock);
    #1 stop = 1'b0;
    check_val("t3_stop_state", 32'({raddr[0], te_w[0], busy_w[0], nv_w[0], done_w[0]}), 32'({7'd1, 4'd0}));
    dcnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (done_w[0]) dcnt++;
    end
    check_val("t3_no_done", dcnt, 0);
    do_start(t);
    check_val("t3_restart_fetch", 32'({raddr[0], busy_w[0]}), 32'({7'd0, 1'b1}));
    do_tick("t3_restart_note", exp_obs(0, 1, 1, 3), t);

    // SONG_LEN=4 with loop: address wraps to 0, never reaches entry 4
    do_reset(); sel = 2;
    for (int i = 0; i < 4; i++) mem[i] = {5'(i + 1), 6'd1};
    do_start(t);
    for (int k = 0; k < 6; k++) do_tick($sformatf("t4_loop_%0d", k), exp_obs(k % 4, 1, 1, (k % 4) + 1), t);
    check_val("t4_loop_busy_done", 32'({busy_w[2], done_w[2]}), 32'b10);

    // SONG_LEN=4 without loop: finish straight after the last entry
    do_reset(); sel = 3;
    for (int i = 0; i < 4; i++) mem[i] = {5'(i + 1), 6'd1};
    do_start(t);
    for (int k = 0; k < 4; k++) do_tick($sformatf("t4_once_%0d", k), exp_obs(k, 1, 1, k + 1), t);
    wait_done(50, at, nvh);
    check_val("t4_once_done_lat", at - t, 1);
    check_val("t4_once_addr", 32'(raddr[3]), 32'd3);

    // reset during PLAY with start and tick coincident
    do_reset(); sel = 0;
    mem[0] = {5'd5, 6'd3};
    do_start(t);
    do_tick("t5_note5", exp_obs(0, 1, 1, 5), t);
    repeat (5) @(posedge clock);
    #1 begin reset = 1'b1; start = 1'b1; tick = 1'b1; end
    @(posedge clock);
    #1 begin reset = 1'b0; start = 1'b0; tick = 1'b0; end
    check_val("t5_reset_outputs",
              32'({raddr[0], note_w[0], nv_w[0], te_w[0], busy_w[0], done_w[0]}), 32'(0));
    @(posedge clock);
    #1 check_val("t5_stays_idle", 32'(busy_w[0]), 32'd0);

    // start and tick together, terminator at entry 0
    do_reset(); sel = 0;
    mem[0] = {5'd6, 6'd0};
    @(posedge clock);
    #1 begin start = 1'b1; tick = 1'b1; end
    t = cyc;
    @(posedge clock);
    #1 begin start = 1'b0; tick = 1'b0; end
    wait_done(20, at, nvh);
    check_val("t6_done_lat", at - t, 3);
    check_val("t6_nv_never", nvh, 0);

    check_val("sb_drain", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
